// File: rtl/burst_mem_adapter.sv
// burst_mem_adapter: memory-side end of the cache line interface.
// Takes one 256-bit line request at a time. A read issues one burst read
// command and gathers BEATS returning beats, filtered by address tag. A
// write-back streams BEATS beats out under bmem_ready flow control.
// Completion is signalled by a one-cycle line_valid (read) or wr_done (write).
module burst_mem_adapter #(
    parameter  int BEATS  = 4,
    parameter  int DATA_W = 64,
    localparam int LINE_W = BEATS * DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       req_addr,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [LINE_W-1:0] req_wdata,
    output logic              up_ready,
    output logic [LINE_W-1:0] line_rdata,
    output logic              line_valid,
    output logic              wr_done,
    output logic [31:0]       bmem_addr,
    output logic              bmem_read,
    output logic              bmem_write,
    output logic [DATA_W-1:0] bmem_wdata,
    input  logic              bmem_ready,
    input  logic [31:0]       bmem_raddr,
    input  logic [DATA_W-1:0] bmem_rdata,
    input  logic              bmem_rvalid
);

    localparam int                CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]     LAST_BEAT  = CW'(BEATS - 1);
    localparam logic [31:0]       LINE_BYTES = 32'(LINE_W / 8);
    // Clears the byte-offset bits so the burst address is line-aligned.
    localparam logic [31:0]       ALIGN_MASK = ~(LINE_BYTES - 32'd1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR_DATA = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [LINE_W-1:0]   wbuf_q, wbuf_d;
    // asm_q collects beats of the read in progress; line_q only changes when
    // a read completes, so a partially filled line is never visible outside.
    logic [LINE_W-1:0]   asm_q, asm_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                lvalid_q, lvalid_d;
    logic                wdone_q, wdone_d;

    logic                beat_hit;
    logic                last_beat;

    assign beat_hit  = bmem_rvalid && (bmem_raddr == addr_q);
    assign last_beat = (cnt_q == LAST_BEAT);

    // up_ready is forced low while reset is held so every output reads 0
    // during reset; it rises as soon as reset is released.
    assign up_ready   = rst_n && (state_q == IDLE);
    assign line_rdata = line_q;
    assign line_valid = lvalid_q;
    assign wr_done    = wdone_q;

    // State, counter, buffers and completion strobes; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wbuf_q   <= '0;
            asm_q    <= '0;
            line_q   <= '0;
            lvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wbuf_q   <= wbuf_d;
            asm_q    <= asm_d;
            line_q   <= line_d;
            lvalid_q <= lvalid_d;
            wdone_q  <= wdone_d;
        end
    end

    // Next-state logic and memory-port outputs for the four-state burst FSM.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wbuf_d     = wbuf_q;
        asm_d      = asm_q;
        line_d     = line_q;
        lvalid_d   = 1'b0;
        wdone_d    = 1'b0;
        bmem_addr  = '0;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_wdata = '0;

        unique case (state_q)
            IDLE: begin
                // A write-back wins when both requests are raised together.
                if (req_write) begin
                    addr_d  = req_addr & ALIGN_MASK;
                    wbuf_d  = req_wdata;
                    cnt_d   = '0;
                    state_d = WR_DATA;
                end else if (req_read) begin
                    addr_d  = req_addr & ALIGN_MASK;
                    cnt_d   = '0;
                    state_d = RD_CMD;
                end
            end

            RD_CMD: begin
                bmem_read = 1'b1;
                bmem_addr = addr_q;
                if (bmem_ready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                bmem_addr = addr_q;
                // Beats tagged with another address belong to someone else.
                if (beat_hit) begin
                    asm_d[int'(cnt_q) * DATA_W +: DATA_W] = bmem_rdata;
                    if (last_beat) begin
                        cnt_d    = '0;
                        line_d   = asm_d;
                        lvalid_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            WR_DATA: begin
                bmem_write = 1'b1;
                bmem_addr  = addr_q;
                bmem_wdata = wbuf_q[int'(cnt_q) * DATA_W +: DATA_W];
                // Beat and strobe are held while the memory stalls.
                if (bmem_ready) begin
                    if (last_beat) begin
                        cnt_d   = '0;
                        wdone_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
